// File: rtl/clyde_pkg.sv
// Shared constants, state encoding and tweak/round-constant update functions
// for the Clyde-128 round schedulers.
package clyde_pkg;

    localparam int NROUNDS = 12;
    localparam int HALF = 64;
    localparam logic [3:0] W_INIT = 4'b0001;

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_ROUND,
        S_DONE
    } state_t;

    // phi({b, a}) = {a, a ^ b}; period 3 over the tweak halves
    function automatic logic [2*HALF-1:0] phi(input logic [2*HALF-1:0] d);
        return {d[HALF-1:0], d[HALF-1:0] ^ d[2*HALF-1:HALF]};
    endfunction

    // Round-constant LFSR step
    function automatic logic [3:0] lfsr(input logic [3:0] w);
        return {w[2:0], w[3] ^ w[0]};
    endfunction

endpackage

// File: rtl/clyde_w_lfsr.sv
// 4-bit round-constant register: reloads W_INIT or advances one LFSR step.
module clyde_w_lfsr
    import clyde_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load,
    input  logic       step,
    output logic [3:0] w
);

    // Load has priority over step; value holds otherwise
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            w <= W_INIT;
        end else if (load) begin
            w <= W_INIT;
        end else if (step) begin
            w <= lfsr(w);
        end
    end

endmodule

// File: rtl/clyde_tk_sched.sv
// Round scheduler and public tweakey-material generator for masked Clyde-128.
// One load cycle, NROUNDS round cycles, one done cycle; outputs decode from
// registers only.
module clyde_tk_sched
    import clyde_pkg::*;
#(
    parameter int Nbits   = 128,
    parameter int NROUNDS = clyde_pkg::NROUNDS
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [Nbits-1:0] tweak,
    output logic             ready,
    output logic             ctrl_load,
    output logic             ctrl_round,
    output logic             ctrl_W_addition,
    output logic             ctrl_TK_addition,
    output logic [3:0]       W,
    output logic [Nbits-1:0] delta,
    output logic             done
);

    localparam int RCW = $clog2(NROUNDS);
    localparam logic [RCW-1:0] RC_LAST = RCW'(NROUNDS - 1);

    state_t         state;
    state_t         state_nxt;
    logic [RCW-1:0] rc;
    logic           accept;
    logic           last_round;

    assign accept     = (state == S_IDLE) && start;
    assign last_round = (state == S_ROUND) && (rc == RC_LAST);

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (start) state_nxt = S_LOAD;
            S_LOAD:  state_nxt = S_ROUND;
            S_ROUND: if (rc == RC_LAST) state_nxt = S_DONE;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Output decode from state and round counter
    always_comb begin
        ready            = 1'b0;
        ctrl_load        = 1'b0;
        ctrl_round       = 1'b0;
        ctrl_W_addition  = 1'b0;
        ctrl_TK_addition = 1'b0;
        done             = 1'b0;
        case (state)
            S_IDLE: ready = 1'b1;
            S_LOAD: begin
                ctrl_load        = 1'b1;
                ctrl_TK_addition = 1'b1;
            end
            S_ROUND: begin
                ctrl_round       = 1'b1;
                ctrl_W_addition  = 1'b1;
                ctrl_TK_addition = rc[0];
            end
            S_DONE:  done = 1'b1;
            default: ready = 1'b0;
        endcase
    end

    // Tweak-derived delta and round counter; phi at LOAD exit and after odd rounds
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            delta <= '0;
            rc    <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        delta <= tweak;
                        rc    <= '0;
                    end
                end
                S_LOAD: delta <= phi(delta);
                S_ROUND: begin
                    if (rc[0]) delta <= phi(delta);
                    rc <= last_round ? '0 : rc + RCW'(1);
                end
                default: rc <= '0;
            endcase
        end
    end

    clyde_w_lfsr u_w_lfsr (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (accept),
        .step  (state == S_ROUND),
        .w     (W)
    );

endmodule

// File: tb/tb_clyde_tk_sched.sv
// Self-checking bench for clyde_tk_sched: phase-based reference model checked
// every cycle, plus directed literal checks and randomized runs.
module tb_clyde_tk_sched;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [127:0] tweak = '0;
    logic         ready, ctrl_load, ctrl_round, ctrl_W_addition, ctrl_TK_addition, done;
    logic [3:0]   W;
    logic [127:0] delta;

    int n_tests = 0;
    int n_fail  = 0;

    clyde_tk_sched #(.Nbits(128), .NROUNDS(12)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .start            (start),
        .tweak            (tweak),
        .ready            (ready),
        .ctrl_load        (ctrl_load),
        .ctrl_round       (ctrl_round),
        .ctrl_W_addition  (ctrl_W_addition),
        .ctrl_TK_addition (ctrl_TK_addition),
        .W                (W),
        .delta            (delta),
        .done             (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    // W during round rc, and after the final round (index 12)
    logic [3:0] wseq [13] = '{4'b0001, 4'b0011, 4'b0111, 4'b1111, 4'b1110, 4'b1101,
                              4'b1010, 4'b0101, 4'b1011, 4'b0110, 4'b1100, 4'b1001,
                              4'b0010};

    // D_i for tweak {t1, t0}
    function automatic logic [127:0] dmat(input logic [127:0] t, input int idx);
        logic [63:0] t0, t1;
        t0 = t[63:0];
        t1 = t[127:64];
        case (idx % 3)
            0:       return {t1, t0};
            1:       return {t0, t0 ^ t1};
            default: return {t0 ^ t1, t1};
        endcase
    endfunction

    // phase 0 = idle, 1 = load, 2..13 = rounds rc 0..11, 14 = done
    int           phase  = 0;
    int           runs   = 0;
    logic [127:0] tw     = '0;
    logic [3:0]   idle_w = 4'b0001;
    logic [127:0] idle_d = '0;

    always @(posedge clk) begin
        if (!rst_n) begin
            phase  = 0;
            idle_w = 4'b0001;
            idle_d = '0;
        end else if (phase == 0) begin
            if (start) begin
                phase = 1;
                tw    = tweak;
                runs++;
            end
        end else if (phase == 14) begin
            phase  = 0;
            idle_w = wseq[12];
            idle_d = dmat(tw, 7);
        end else begin
            phase++;
        end
    end

    logic         chk_en = 1'b0;
    logic [5:0]   e_ctl;
    logic [3:0]   e_w;
    logic [127:0] e_d;
    int           rcm;

    // Every-cycle comparison against the model
    always @(negedge clk) begin
        if (chk_en) begin
            e_ctl = '0;
            if (phase == 0) begin
                e_ctl = 6'b100000;
                e_w   = idle_w;
                e_d   = idle_d;
            end else if (phase == 1) begin
                e_ctl = 6'b010010;
                e_w   = 4'b0001;
                e_d   = dmat(tw, 0);
            end else if (phase <= 13) begin
                rcm      = phase - 2;
                e_ctl    = {4'b0011, rcm[0], 1'b0};
                e_w      = wseq[rcm];
                e_d      = dmat(tw, 1 + rcm / 2);
            end else begin
                e_ctl = 6'b000001;
                e_w   = wseq[12];
                e_d   = dmat(tw, 7);
            end
            chk("ctrl{rdy,ld,rnd,wa,tk,done}",
                128'({ready, ctrl_load, ctrl_round, ctrl_W_addition, ctrl_TK_addition, done}),
                128'(e_ctl));
            chk("W", 128'(W), 128'(e_w));
            chk("delta", delta, e_d);
        end
    end

    // ---------------- stimulus ----------------
    task automatic wait_ready(input string name);
        int budget;
        budget = 0;
        while (!ready && budget < 40) begin
            @(negedge clk);
            budget++;
        end
        if (!ready) chk({name, "_ready_timeout"}, 128'(0), 128'(1));
    endtask

    initial begin : stim
        int cnt;
        int seen_done;
        int gap;
        int target;
        int cyc;

        @(negedge clk);
        chk_en = 1'b1;
        repeat (2) @(negedge clk);
        chk("reset_ready", 128'(ready), 128'(1));
        chk("reset_W", 128'(W), 128'(4'b0001));
        chk("reset_delta", delta, 128'(0));
        rst_n = 1'b1;
        @(negedge clk);

        // Nominal run with literal expectations
        start = 1'b1;
        tweak = {64'h0, 64'h1};
        @(negedge clk);
        start = 1'b0;
        tweak = '1;
        chk("lit_load_strobe", 128'({ctrl_load, ctrl_TK_addition}), 128'(2'b11));
        chk("lit_load_delta", delta, 128'h1);
        repeat (2) @(negedge clk);
        chk("lit_rc1_delta", delta, {64'h1, 64'h1});
        chk("lit_rc1_tk", 128'(ctrl_TK_addition), 128'(1));
        repeat (2) @(negedge clk);
        chk("lit_rc3_delta", delta, {64'h1, 64'h0});
        repeat (2) @(negedge clk);
        chk("lit_rc5_delta", delta, 128'h1);
        cnt = 7;
        while (!done && cnt < 30) begin
            @(negedge clk);
            cnt++;
        end
        chk("lit_done_latency", 128'(cnt), 128'(14));
        @(negedge clk);
        chk("lit_ready_after_done", 128'(ready), 128'(1));
        chk("lit_idle_W", 128'(W), 128'(4'b0010));

        // start held high through a run, tweak churning; re-accept as soon as ready
        start = 1'b1;
        tweak = 128'hA5A5_0000_1111_2222_3333_4444_5555_6666;
        @(negedge clk);
        cnt = 0;
        do begin
            tweak = {$urandom, $urandom, $urandom, $urandom};
            @(negedge clk);
            cnt++;
        end while (!ctrl_load && cnt < 40);
        chk("lit_restart_spacing", 128'(cnt), 128'(15));
        chk("lit_restart_W", 128'(W), 128'(4'b0001));
        start = 1'b0;
        wait_ready("held");

        // Reset mid-run at rc=5
        start = 1'b1;
        tweak = {$urandom, $urandom, $urandom, $urandom};
        @(negedge clk);
        start = 1'b0;
        repeat (6) @(negedge clk);
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        chk("rst_mid_ctrl",
            128'({ready, ctrl_load, ctrl_round, ctrl_W_addition, ctrl_TK_addition, done}),
            128'(6'b100000));
        chk("rst_mid_W", 128'(W), 128'(4'b0001));
        seen_done = 0;
        repeat (20) begin
            @(negedge clk);
            if (done) seen_done++;
        end
        chk("rst_mid_no_done", 128'(seen_done), 128'(0));

        // Randomized runs: random start gaps, random tweaks, rare resets
        target = runs + 1000;
        cyc    = 0;
        while (runs < target && cyc < 60000) begin
            gap   = $urandom_range(0, 3);
            start = (gap == 0) || ($urandom_range(0, 1) == 1);
            tweak = {$urandom, $urandom, $urandom, $urandom};
            rst_n = ($urandom_range(0, 299) != 0);
            @(negedge clk);
            cyc++;
        end
        rst_n = 1'b1;
        start = 1'b0;
        chk("random_runs_complete", 128'(runs >= target), 128'(1));
        repeat (20) @(negedge clk);

        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/clyde_tk_sched.md
Name: clyde_tk_sched

Overview:
- Round scheduler and public tweakey-material generator for the masked Clyde-128 core.
- Sits directly upstream of the tweakey/W addition stage and drives it every cycle.
- Outputs: unmasked tweak-derived delta, 4-bit round constant W, and the TK/W/round/load control strobes.
- Runs the fixed sequence: one load cycle, then NROUNDS round cycles, with a start/ready/done handshake toward the mode controller.

Parameters:
- Nbits, 128, state/tweak width; fixed at 128 (two 64-bit tweak halves).
- NROUNDS, 12, number of Clyde rounds; must be even (2 rounds per step).

Ports:
- clk  input  1  clock
- rst_n  input  1  reset, synchronous, active-low
- start  input  1  request a new encryption; accepted when start & ready
- tweak  input  Nbits  public tweak T = {t1, t0}, t0 = tweak[63:0]; sampled on acceptance
- ready  output  1  block idle, can accept start
- ctrl_load  output  1  datapath loads the fresh state sharing this cycle
- ctrl_round  output  1  datapath applies S-box/L-box this cycle
- ctrl_W_addition  output  1  W must be added this cycle
- ctrl_TK_addition  output  1  tweakey must be added this cycle
- W  output  4  current round constant
- delta  output  Nbits  current tweak-derived value, {b, a}, a = delta[63:0]
- done  output  1  single-cycle pulse: final round completed

Behaviour:
- States: IDLE, LOAD, ROUND, DONE. All outputs registered/decoded from registers; no input-to-output combinational path.
- Reset (rst_n=0 at clk edge):
  - state=IDLE, ready=1, all ctrl_* = 0, done=0, W=4'b0001, delta=0, round counter rc=0.
  - Reset mid-operation aborts immediately with the same values.
- IDLE:
  - ready=1; all ctrl_* = 0.
  - On start=1: delta<=tweak, W<=4'b0001, rc<=0, go to LOAD.
  - Otherwise hold.
- LOAD (exactly 1 cycle):
  - ready=0, ctrl_load=1, ctrl_TK_addition=1, ctrl_W_addition=0, ctrl_round=0. delta = D0 = {t1, t0}.
  - At exit: delta<=phi(delta); go to ROUND.
- phi({b, a}) = {a, a^b}, i.e. new a = a^b, new b = a.
  - D1 = {t0, t0^t1}, D2 = {t0^t1, t1}, D3 = D0 (period 3).
- ROUND (NROUNDS cycles, rc = 0..NROUNDS-1):
  - ctrl_round=1 and ctrl_W_addition=1 every round cycle; W = w_rc.
  - ctrl_TK_addition = rc[0]: TK added after every odd round (end of step), using delta currently held.
  - Every round cycle: W <= lfsr(W), where lfsr(w) = {w[2:0], w[3]^w[0]}.
  - Odd rc only: delta <= phi(delta).
  - rc increments each cycle. When rc = NROUNDS-1, go to DONE (rc<=0).
- W sequence from reset/start: 0001, 0011, 0111, 1111, 1110, 1101, 1010, 0101, 1011, 0110, 1100, 1001, 0010, ...
- Step s (s = 0..NROUNDS/2) therefore adds delta D_(s mod 3). Step 0 is the LOAD cycle.
- DONE (1 cycle):
  - done=1, all ctrl_* = 0, ready=0; then go to IDLE.
  - ready rises the cycle after done.
- start is ignored in every state except IDLE; tweak changes outside acceptance have no effect.
- delta and W hold their register values even when the matching ctrl is 0. Gating is done downstream.
- Latency: start accepted at edge k → LOAD during cycle k+1, rounds k+2..k+1+NROUNDS, done at k+2+NROUNDS, ready at k+3+NROUNDS.
- Minimum start-to-start spacing: NROUNDS+3 cycles.

Decomposition:
- Package clyde_pkg holds:
  - NROUNDS;
  - W_INIT = 4'b0001;
  - state encoding (IDLE, LOAD, ROUND, DONE);
  - HALF = 64;
  - phi and lfsr as functions.
- One sub-module: clyde_w_lfsr (4-bit register, load/step enable, synchronous active-low reset), reusable by the decryption scheduler.

Test Plan:
- Reset: hold rst_n=0 three cycles mid-run (rc=5) → next cycle ready=1, all ctrl=0, W=0001, done=0; no done pulse follows.
- Nominal run, tweak = {64'h0, 64'h1} → check the TK-addition cycles:
  - LOAD: delta=128'h0000..0000_0000..0001.
  - rc=1: delta = {64'h1, 64'h1}.
  - rc=3: delta = {64'h1, 64'h0}.
  - rc=5: back to D0.
  - done exactly at cycle 14 after acceptance.
- W trace: W during rc=0..11 equals 0001, 0011, 0111, 1111, 1110, 1101, 1010, 0101, 1011, 0110, 1100, 1001. ctrl_TK_addition high only at LOAD and odd rc.
- start held high during the busy period → ignored. Second accepted start occurs only after ready returns (15 cycles from the first acceptance). The second run restarts W at 0001 and uses the new tweak.
- Back-to-back: start asserted the cycle ready rises → LOAD the next cycle; no idle gap beyond the specified one; done pulses exactly once per run.
- Random tweaks (1000 runs) vs. reference model of phi/lfsr → all delta/W/ctrl values match on every cycle.
